// File: rtl/qam_sym_gen_pkg.sv
// ---------------------------------------------------------------------------
// qam_sym_gen_pkg
// Shared definitions for the QAM symbol generator:
//   - FSM state encoding
//   - default pattern register width and seed
//   - PRBS-7 (x^7 + x^6 + 1) tap mask and seed
//   - bits-per-symbol constants for the supported constellation orders
// ---------------------------------------------------------------------------
package qam_sym_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam int          DEFAULT_PAT_W = 28;
    localparam int          DEFAULT_DIV_W = 10;
    localparam logic [27:0] DEFAULT_SEED  = 28'h6CC1555;

    // Fibonacci PRBS-7: feedback is the XOR of stages 7 and 6 (bits 6 and 5)
    localparam int          PRBS7_W    = 7;
    localparam logic [6:0]  PRBS7_SEED = 7'h7F;
    localparam logic [6:0]  PRBS7_TAPS = 7'b110_0000;

    localparam int          QAM4_SYM_BITS  = 2;
    localparam int          QAM16_SYM_BITS = 4;

endpackage

// File: rtl/qam_edge_det.sv
// ---------------------------------------------------------------------------
// qam_edge_det
// Rising-edge detector used to turn the enable_cntr level into single-cycle
// ticks. The input is registered once; rise is high in the cycle where the
// input is 1 and its registered copy is still 0.
//
// Ports:
//   clock  in   single clock, rising edge
//   reset  in   asynchronous active-high reset (clears the history to 0)
//   d      in   level to watch
//   rise   out  one-cycle pulse on each 0->1 transition of d
// ---------------------------------------------------------------------------
module qam_edge_det (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic rise
);

    logic r_q;

    // History register holding last cycle's value of d
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q <= 1'b0;
        end else begin
            r_q <= d;
        end
    end

    assign rise = d & ~r_q;

endmodule

// File: rtl/qam_sym_gen.sv
// ---------------------------------------------------------------------------
// qam_sym_gen
// Emits QAM symbols of SYM_BITS bits at a programmable tick rate. Ticks come
// from rising edges of enable_cntr; a symbol is due every sym_period+1 ticks.
// Symbols come from a rotating pattern register or, when built with the
// optional PRBS-7 generator, from an LFSR selected by prbs_mode. Output uses
// a valid/ready handshake; a symbol due while the previous one is still
// unaccepted is dropped and flagged by the sticky overrun bit.
//
// Optional feature macro:
//   QAM_SYM_GEN_PRBS_EN  builds the PRBS-7 source; otherwise prbs_mode is
//                        ignored and the pattern register is always used.
//
// Parameters:
//   PAT_W     pattern register width (multiple of SYM_BITS)
//   SYM_BITS  bits per symbol (2 = QAM-4, 4 = QAM-16)
//   DIV_W     width of tick counter and sym_period
//   SEED      pattern register reset value
//
// Ports:
//   clock        in   single clock, rising edge
//   reset        in   asynchronous active-high reset
//   enable_cntr  in   tick source, each 0->1 transition is one tick
//   start        in   pulse, IDLE -> RUN (also clears overrun)
//   stop         in   pulse, RUN/STALL -> IDLE (wins over start)
//   sym_period   in   symbol every sym_period+1 ticks
//   prbs_mode    in   1 = PRBS source, 0 = pattern source
//   sym_ready    in   consumer accepts sym_data when sym_valid && sym_ready
//   sym_data     out  registered current symbol
//   sym_valid    out  sym_data holds an unaccepted symbol
//   data_change  out  one-cycle pulse on the cycle after sym_data loads
//   overrun      out  sticky, a symbol was dropped
//   busy         out  high in RUN or STALL
// ---------------------------------------------------------------------------
module qam_sym_gen
    import qam_sym_gen_pkg::*;
#(
    parameter int               PAT_W    = DEFAULT_PAT_W,
    parameter int               SYM_BITS = QAM4_SYM_BITS,
    parameter int               DIV_W    = DEFAULT_DIV_W,
    parameter logic [PAT_W-1:0] SEED     = PAT_W'(DEFAULT_SEED)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable_cntr,
    input  logic                start,
    input  logic                stop,
    input  logic [DIV_W-1:0]    sym_period,
    input  logic                prbs_mode,
    input  logic                sym_ready,
    output logic [SYM_BITS-1:0] sym_data,
    output logic                sym_valid,
    output logic                data_change,
    output logic                overrun,
    output logic                busy
);

    state_t                r_state;
    state_t                w_stateNext;
    logic [DIV_W-1:0]      r_cntr;
    logic [DIV_W-1:0]      w_cntrNext;
    logic [PAT_W-1:0]      r_pat;
    logic [PAT_W-1:0]      w_patNext;
    logic [SYM_BITS-1:0]   w_patSym;
    logic [SYM_BITS-1:0]   w_srcSym;
    logic                  w_patAdv;
    logic [SYM_BITS-1:0]   r_symData;
    logic                  r_symValid;
    logic                  r_dataChange;
    logic                  r_overrun;
    logic                  w_tick;
    logic                  w_busy;
    logic                  w_run;
    logic                  w_due;
    logic                  w_load;
    logic                  w_drop;
    logic                  w_accept;

    qam_edge_det u_tick (
        .clock (clock),
        .reset (reset),
        .d     (enable_cntr),
        .rise  (w_tick)
    );

    // A stop cycle is treated as already idle so no symbol is loaded or
    // counted on the way out of RUN/STALL.
    assign w_busy   = (r_state != ST_IDLE);
    assign w_run    = w_busy && !stop;
    assign w_due    = w_run && w_tick && (r_cntr >= sym_period);
    assign w_accept = r_symValid && sym_ready;
    assign w_load   = w_due && (!r_symValid || sym_ready);
    assign w_drop   = w_due && r_symValid && !sym_ready;

    // Pattern source: top SYM_BITS are the symbol, advance is a left rotate
    assign w_patSym  = r_pat[PAT_W-1 -: SYM_BITS];
    assign w_patNext = {r_pat[PAT_W-SYM_BITS-1:0], w_patSym};

`ifdef QAM_SYM_GEN_PRBS_EN
    logic [PRBS7_W-1:0]  r_lfsr;
    logic [PRBS7_W-1:0]  w_lfsrNext;
    logic [SYM_BITS-1:0] w_prbsSym;
    logic                w_lfsrAdv;

    // Step the LFSR SYM_BITS times; the MSB seen before each step becomes
    // the next symbol bit, first bit landing in the symbol MSB.
    always_comb begin : prbsStep
        logic [PRBS7_W-1:0] v_lfsr;
        v_lfsr    = r_lfsr;
        w_prbsSym = '0;
        for (int i = 0; i < SYM_BITS; i++) begin
            w_prbsSym[SYM_BITS-1-i] = v_lfsr[PRBS7_W-1];
            v_lfsr = {v_lfsr[PRBS7_W-2:0], ^(v_lfsr & PRBS7_TAPS)};
        end
        w_lfsrNext = v_lfsr;
    end

    // Only the source actually supplying the symbol advances, so switching
    // modes leaves the other source where it was.
    assign w_srcSym  = prbs_mode ? w_prbsSym : w_patSym;
    assign w_patAdv  = w_load && !prbs_mode;
    assign w_lfsrAdv = w_load && prbs_mode;

    // LFSR state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lfsr <= PRBS7_SEED;
        end else if (w_lfsrAdv) begin
            r_lfsr <= w_lfsrNext;
        end
    end
`else
    logic w_unused_prbsMode;

    assign w_unused_prbsMode = prbs_mode;
    assign w_srcSym          = w_patSym;
    assign w_patAdv          = w_load;
`endif

    // Next-state logic. Stop has priority everywhere; a drop in RUN means
    // the consumer is backed up, and STALL is left once it accepts.
    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start && !stop) begin
                    w_stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                if (stop) begin
                    w_stateNext = ST_IDLE;
                end else if (w_drop) begin
                    w_stateNext = ST_STALL;
                end
            end
            ST_STALL: begin
                if (stop) begin
                    w_stateNext = ST_IDLE;
                end else if (w_accept) begin
                    w_stateNext = ST_RUN;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    // Tick counter. Held at zero while idle; the >= compare means a period
    // lowered below the current count fires on the very next tick instead
    // of wrapping around the counter range.
    always_comb begin
        w_cntrNext = r_cntr;
        if (!w_run) begin
            w_cntrNext = '0;
        end else if (w_tick) begin
            if (r_cntr >= sym_period) begin
                w_cntrNext = '0;
            end else begin
                w_cntrNext = r_cntr + DIV_W'(1);
            end
        end
    end

    // FSM state and counter registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cntr  <= '0;
        end else begin
            r_state <= w_stateNext;
            r_cntr  <= w_cntrNext;
        end
    end

    // Pattern register; keeps its value while idle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pat <= SEED;
        end else if (w_patAdv) begin
            r_pat <= w_patNext;
        end
    end

    // Output symbol register and handshake. sym_data holds through idle and
    // through dropped symbols; sym_valid clears in idle and after acceptance
    // unless a new symbol loads in the same cycle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_symData    <= '0;
            r_symValid   <= 1'b0;
            r_dataChange <= 1'b0;
        end else begin
            r_dataChange <= w_load;
            if (w_load) begin
                r_symData <= w_srcSym;
            end
            if (!w_busy) begin
                r_symValid <= 1'b0;
            end else if (w_load) begin
                r_symValid <= 1'b1;
            end else if (w_accept) begin
                r_symValid <= 1'b0;
            end
        end
    end

    // Sticky overrun flag; a drop in the same cycle as start still records
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (start) begin
            r_overrun <= 1'b0;
        end
    end

    assign sym_data    = r_symData;
    assign sym_valid   = r_symValid;
    assign data_change = r_dataChange;
    assign overrun     = r_overrun;
    assign busy        = w_busy;

endmodule
